driver_pattern_stage: RTL and testbench
=======================================

# driver_pattern_stage

Downstream consumer of the backend cycle controller. It loads row and column data words from the pattern memory at the addresses the controller selects, and applies per-driver row/column selection and inversion. It then drives complementary driver outputs with a programmable break-before-make dead time for as long as `output_active` is held. It sits between the cycle controller and the pad drivers.

## Interface
Parameters:
- `MEM_ADDRESS_LENGTH`, 7: width of row/column select; the memory address is one bit wider.
- `NUM_OF_DRIVERS`, 16: number of driver channels, and the memory word width.
- `DEAD_TIME_WIDTH`, 8: width of `dead_time`.

Ports:
- `clock`, in, 1: single clock; all logic is posedge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `output_active`, in, 1: drive window from the controller.
- `update_cycle_complete`, in, 1: controller sequence done; forces idle.
- `row_select`, in, `MEM_ADDRESS_LENGTH`: row word address.
- `col_select`, in, `MEM_ADDRESS_LENGTH`: column word address.
- `inverter_select`, in, `NUM_OF_DRIVERS`: bit i = 1 inverts channel i.
- `row_col_select`, in, `NUM_OF_DRIVERS`: bit i = 1 takes channel i from the column word, 0 from the row word.
- `dead_time`, in, `DEAD_TIME_WIDTH`: all-off cycles inserted before drive; static config.
- `mem_address`, out, `MEM_ADDRESS_LENGTH+1`: MSB is the bank (0 = row, 1 = col); low bits are the word address.
- `mem_read_n`, out, 1: active-low read strobe.
- `mem_data`, in, `NUM_OF_DRIVERS`: read data, valid the cycle after the strobe.
- `driver_p`, out, `NUM_OF_DRIVERS`: high-side enables.
- `driver_n`, out, `NUM_OF_DRIVERS`: low-side enables.
- `busy`, out, 1: high when the state is not IDLE.

## Operation
- States: IDLE, READ_ROW, READ_COL, CAPTURE, DEAD, DRIVE.
- **Start:** a rising edge of `output_active` (registered previous value is 0, current is 1) with `update_cycle_complete` = 0 moves IDLE to READ_ROW.
  - On that edge, `row_select`, `col_select`, `inverter_select` and `row_col_select` are latched.
  - Later changes to these inputs are ignored until the next start.
- **READ_ROW:** `mem_address` = {0, row}, `mem_read_n` = 0. Next state is READ_COL.
- **READ_COL:**
  - Capture `mem_data` as the row word.
  - `mem_address` = {1, col}, `mem_read_n` = 0.
  - Next state is CAPTURE.
- **CAPTURE:**
  - Capture `mem_data` as the column word.
  - pattern[i] = (rcs[i] ? col_word[i] : row_word[i]) ^ inv[i].
  - Next state is DEAD, or DRIVE if `dead_time` = 0.
- **DEAD:** the counter loads `dead_time` on entry and counts down. The state exits to DRIVE when the count reaches 1, giving exactly `dead_time` cycles in DEAD.
- **DRIVE:** `driver_p` = pattern, `driver_n` = ~pattern. Stays while `output_active` = 1.
- **Abort:** `output_active` = 0 or `update_cycle_complete` = 1 in any non-IDLE state moves to IDLE.
  - All driver outputs go to 0.
  - An in-flight read is dropped.
- **Re-start:** requires a new rising edge; a held-high `output_active` never re-triggers.
- **Invariant:** `driver_p[i]` & `driver_n[i]` is never 1. Outside DRIVE, both are 0.
- **Memory strobe:** `mem_read_n` = 1 and `mem_address` holds its last value in every state except READ_ROW and READ_COL.

## Timing
- All outputs are registered.
- Reset values: `driver_p` = 0, `driver_n` = 0, `mem_read_n` = 1, `mem_address` = 0, `busy` = 0. State is IDLE and the previous-active register is 0.
- Start edge at cycle 0:
  - READ_ROW strobe is visible in cycle 1.
  - READ_COL strobe in cycle 2.
  - CAPTURE in cycle 3.
  - Driver outputs are valid from cycle 4 + `dead_time`.
- The falling edge of `output_active` is sampled at edge k. Drivers are 0 in cycle k+1; the deassertion latency is one cycle.
- Simultaneous rising edge and `update_cycle_complete` = 1: stays IDLE.
- Asynchronous reset mid-DRIVE: outputs go to 0 immediately, without waiting for a clock edge.

## Structure
- Shared package holds:
  - the state encoding localparams;
  - bank constants `BANK_ROW` = 0 and `BANK_COL` = 1.
- Sub-module `active_edge_detect`: registered rise detector with asynchronous active-low reset. It is instantiated once for `output_active`.
- The dead-time counter and FSM stay in the top module.

## Test plan
- **Dead time 0:** memory row 3 = 0x00FF, col 5 = 0xF0F0, `rcs` = 0xFF00, `inv` = 0x0001, `dead_time` = 0, rise with row 3 / col 5.
  - Required: `driver_p` = 0xF0FE and `driver_n` = 0x0F01 in cycle 4.
  - Required: memory reads of {0,3} and then {1,5}.
- **Dead time 5:** same stimulus. Drivers are 0 for cycles 4–8 and 0xF0FE from cycle 9.
- **Abort:** drop `output_active` during READ_COL or DEAD. Drivers remain 0, `busy` falls next cycle, no DRIVE occurs.
- **Completion:** `update_cycle_complete` = 1 together with a rise results in no reads. In DRIVE it zeroes the drivers within one cycle.
- **Held input:** hold `output_active` high for 100 cycles while toggling `row_select`. Exactly one read pair occurs and the pattern is unchanged.
- **Reset mid-DRIVE:** assert `reset_n` = 0 mid-DRIVE. Outputs go to 0 asynchronously and `mem_read_n` = 1. Check the `driver_p` & `driver_n` = 0 invariant every cycle throughout.

Source files
------------

// File: rtl/driver_pattern_stage_pkg.sv
// Shared definitions for the driver pattern stage: FSM states and memory bank selects.
package driver_pattern_stage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ_ROW = 3'd1,
        ST_READ_COL = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_DEAD     = 3'd4,
        ST_DRIVE    = 3'd5
    } state_t;

    // Bank bit prepended to the word address on mem_address.
    localparam logic BANK_ROW = 1'b0;
    localparam logic BANK_COL = 1'b1;

endpackage

// File: rtl/driver_pattern_stage_active_edge_detect.sv
// Rise detector: flags a 0->1 transition of signal_in against its registered previous value.
module active_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic signal_in,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= signal_in;
        end
    end

    assign rise = signal_in & ~prev_q;

endmodule

// File: rtl/driver_pattern_stage.sv
// Loads row/column pattern words from memory, applies per-channel select and inversion,
// and drives complementary outputs after a programmable all-off dead time.
module driver_pattern_stage
    import driver_pattern_stage_pkg::*;
#(
    parameter int MEM_ADDRESS_LENGTH = 7,
    parameter int NUM_OF_DRIVERS     = 16,
    parameter int DEAD_TIME_WIDTH    = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            output_active,
    input  logic                            update_cycle_complete,
    input  logic [MEM_ADDRESS_LENGTH-1:0]   row_select,
    input  logic [MEM_ADDRESS_LENGTH-1:0]   col_select,
    input  logic [NUM_OF_DRIVERS-1:0]       inverter_select,
    input  logic [NUM_OF_DRIVERS-1:0]       row_col_select,
    input  logic [DEAD_TIME_WIDTH-1:0]      dead_time,
    output logic [MEM_ADDRESS_LENGTH:0]     mem_address,
    output logic                            mem_read_n,
    input  logic [NUM_OF_DRIVERS-1:0]       mem_data,
    output logic [NUM_OF_DRIVERS-1:0]       driver_p,
    output logic [NUM_OF_DRIVERS-1:0]       driver_n,
    output logic                            busy
);

    localparam logic [DEAD_TIME_WIDTH-1:0] DT_ONE = DEAD_TIME_WIDTH'(1);

    state_t                          state;
    logic                            active_rise;
    logic                            abort;
    logic [MEM_ADDRESS_LENGTH-1:0]   col_sel_q;
    logic [NUM_OF_DRIVERS-1:0]       inv_sel_q;
    logic [NUM_OF_DRIVERS-1:0]       rcs_sel_q;
    logic [NUM_OF_DRIVERS-1:0]       row_word;
    logic [NUM_OF_DRIVERS-1:0]       pattern_q;
    logic [NUM_OF_DRIVERS-1:0]       pattern_next;
    logic [DEAD_TIME_WIDTH-1:0]      dead_cnt;

    active_edge_detect u_active_edge (
        .clock     (clock),
        .reset_n   (reset_n),
        .signal_in (output_active),
        .rise      (active_rise)
    );

    assign abort = ~output_active | update_cycle_complete;

    // Column word arrives on mem_data during CAPTURE; row word was stored a cycle earlier.
    always_comb begin
        pattern_next = ((rcs_sel_q & mem_data) | (~rcs_sel_q & row_word)) ^ inv_sel_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            col_sel_q   <= '0;
            inv_sel_q   <= '0;
            rcs_sel_q   <= '0;
            row_word    <= '0;
            pattern_q   <= '0;
            dead_cnt    <= '0;
            mem_address <= '0;
            mem_read_n  <= 1'b1;
            driver_p    <= '0;
            driver_n    <= '0;
            busy        <= 1'b0;
        end else if (state == ST_IDLE) begin
            driver_p   <= '0;
            driver_n   <= '0;
            mem_read_n <= 1'b1;
            if (active_rise && !update_cycle_complete) begin
                // Row address is consumed on this edge, so only the later-used selects are held.
                col_sel_q   <= col_select;
                inv_sel_q   <= inverter_select;
                rcs_sel_q   <= row_col_select;
                mem_address <= {BANK_ROW, row_select};
                mem_read_n  <= 1'b0;
                busy        <= 1'b1;
                state       <= ST_READ_ROW;
            end
        end else if (abort) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            mem_read_n <= 1'b1;
            driver_p   <= '0;
            driver_n   <= '0;
        end else begin
            case (state)
                ST_READ_ROW: begin
                    mem_address <= {BANK_COL, col_sel_q};
                    mem_read_n  <= 1'b0;
                    state       <= ST_READ_COL;
                end
                ST_READ_COL: begin
                    row_word   <= mem_data;
                    mem_read_n <= 1'b1;
                    state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    pattern_q <= pattern_next;
                    if (dead_time == '0) begin
                        driver_p <= pattern_next;
                        driver_n <= ~pattern_next;
                        state    <= ST_DRIVE;
                    end else begin
                        dead_cnt <= dead_time;
                        state    <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt == DT_ONE) begin
                        driver_p <= pattern_q;
                        driver_n <= ~pattern_q;
                        state    <= ST_DRIVE;
                    end else begin
                        dead_cnt <= dead_cnt - DT_ONE;
                    end
                end
                ST_DRIVE: begin
                    driver_p <= pattern_q;
                    driver_n <= ~pattern_q;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    driver_p <= '0;
                    driver_n <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_driver_pattern_stage.sv
// Scoreboard bench for driver_pattern_stage: stimulus queues expected reads and driver changes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_driver_pattern_stage;

    typedef struct {
        int          cyc;
        logic [15:0] p;
        logic [15:0] n;
    } drv_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        output_active;
    logic        update_cycle_complete;
    logic [6:0]  row_select;
    logic [6:0]  col_select;
    logic [15:0] inverter_select;
    logic [15:0] row_col_select;
    logic [7:0]  dead_time;
    logic [7:0]  mem_address;
    logic        mem_read_n;
    logic [15:0] mem_data;
    logic [15:0] driver_p;
    logic [15:0] driver_n;
    logic        busy;

    logic [15:0] mem [0:255];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          s;
    logic [7:0]  rd_q[$];
    drv_t        drv_q[$];
    logic [31:0] last_pn = '0;
    logic [7:0]  exp_addr;
    drv_t        exp_drv;

    always #5 clock = ~clock;

    driver_pattern_stage #(
        .MEM_ADDRESS_LENGTH (7),
        .NUM_OF_DRIVERS     (16),
        .DEAD_TIME_WIDTH    (8)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .output_active         (output_active),
        .update_cycle_complete (update_cycle_complete),
        .row_select            (row_select),
        .col_select            (col_select),
        .inverter_select       (inverter_select),
        .row_col_select        (row_col_select),
        .dead_time             (dead_time),
        .mem_address           (mem_address),
        .mem_read_n            (mem_read_n),
        .mem_data              (mem_data),
        .driver_p              (driver_p),
        .driver_n              (driver_n),
        .busy                  (busy)
    );

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_read_n == 1'b0) mem_data <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [6:0] r, input logic [6:0] c,
                         input logic [15:0] rcs, input logic [15:0] inv);
        row_select      = r;
        col_select      = c;
        row_col_select  = rcs;
        inverter_select = inv;
        output_active   = 1'b1;
        rd_q.push_back({1'b0, r});
        rd_q.push_back({1'b1, c});
    endtask

    task automatic stop_active();
        output_active = 1'b0;
        drv_q.push_back('{cyc: cyc + 1, p: 16'h0000, n: 16'h0000});
        repeat (3) tick();
    endtask

    // Monitor: invariant every cycle, reads and driver transitions against the queues.
    always @(negedge clock) begin
        chk("overlap", {16'h0, driver_p & driver_n}, 32'h0);
        if (mem_read_n === 1'b0) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read: unexpected address %h, expected no read (cycle %0d)", mem_address, cyc);
            end else begin
                exp_addr = rd_q.pop_front();
                chk("read_addr", {24'h0, mem_address}, {24'h0, exp_addr});
            end
        end
        if ({driver_p, driver_n} !== last_pn) begin
            if (drv_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drive: unexpected p=%h n=%h, expected no change (cycle %0d)", driver_p, driver_n, cyc);
            end else begin
                exp_drv = drv_q.pop_front();
                chk("drive_cycle", cyc, exp_drv.cyc);
                chk("drive_p", {16'h0, driver_p}, {16'h0, exp_drv.p});
                chk("drive_n", {16'h0, driver_n}, {16'h0, exp_drv.n});
            end
            last_pn = {driver_p, driver_n};
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[3]   = 16'h00FF;
        mem[133] = 16'hF0F0;
        mem[7]   = 16'h1234;
        mem[137] = 16'hABCD;
        mem_data              = 16'h0000;
        reset_n               = 1'b0;
        output_active         = 1'b0;
        update_cycle_complete = 1'b0;
        row_select            = '0;
        col_select            = '0;
        inverter_select       = '0;
        row_col_select        = '0;
        dead_time             = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_p", {16'h0, driver_p}, 32'h0);
        chk("reset_n", {16'h0, driver_n}, 32'h0);
        chk("reset_rd", {31'h0, mem_read_n}, 32'h1);
        chk("reset_addr", {24'h0, mem_address}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Dead time 0; selects changed after the start must be ignored.
        dead_time = 8'd0;
        start(7'd3, 7'd5, 16'hFF00, 16'h0001);
        s = cyc;
        drv_q.push_back('{cyc: s + 4, p: 16'hF0FE, n: 16'h0F01});
        tick();
        row_select = 7'd7; col_select = 7'd9; row_col_select = 16'h0000; inverter_select = 16'hFFFF;
        repeat (7) tick();
        chk("dt0_busy", {31'h0, busy}, 32'h1);
        stop_active();
        chk("dt0_idle", {31'h0, busy}, 32'h0);

        // Dead time 5.
        dead_time = 8'd5;
        start(7'd3, 7'd5, 16'hFF00, 16'h0001);
        s = cyc;
        drv_q.push_back('{cyc: s + 9, p: 16'hF0FE, n: 16'h0F01});
        repeat (8) tick();
        chk("dt5_dead_p", {16'h0, driver_p}, 32'h0);
        chk("dt5_busy", {31'h0, busy}, 32'h1);
        repeat (4) tick();
        stop_active();

        // Abort during READ_COL.
        dead_time = 8'd0;
        start(7'd3, 7'd5, 16'hFF00, 16'h0001);
        repeat (2) tick();
        output_active = 1'b0;
        tick();
        chk("abort_col_busy", {31'h0, busy}, 32'h0);
        repeat (6) tick();

        // Abort during DEAD.
        dead_time = 8'd5;
        start(7'd3, 7'd5, 16'hFF00, 16'h0001);
        repeat (5) tick();
        output_active = 1'b0;
        tick();
        chk("abort_dead_busy", {31'h0, busy}, 32'h0);
        repeat (10) tick();

        // Completion together with a rise: no reads.
        dead_time = 8'd0;
        update_cycle_complete = 1'b1;
        output_active = 1'b1;
        repeat (3) tick();
        chk("ucc_rise_busy", {31'h0, busy}, 32'h0);
        output_active = 1'b0;
        update_cycle_complete = 1'b0;
        repeat (2) tick();

        // Completion while driving; held-high active must not re-trigger.
        start(7'd3, 7'd5, 16'hFF00, 16'h0001);
        s = cyc;
        drv_q.push_back('{cyc: s + 4, p: 16'hF0FE, n: 16'h0F01});
        repeat (6) tick();
        update_cycle_complete = 1'b1;
        drv_q.push_back('{cyc: cyc + 1, p: 16'h0000, n: 16'h0000});
        tick();
        chk("ucc_drive_busy", {31'h0, busy}, 32'h0);
        update_cycle_complete = 1'b0;
        repeat (5) tick();
        chk("no_retrigger", {31'h0, busy}, 32'h0);
        output_active = 1'b0;
        repeat (2) tick();

        // Held active for 100 cycles with row_select toggling.
        dead_time = 8'd2;
        start(7'd7, 7'd9, 16'h00FF, 16'hFFFF);
        s = cyc;
        drv_q.push_back('{cyc: s + 6, p: 16'hED32, n: 16'h12CD});
        for (int unsigned i = 0; i < 100; i++) begin
            tick();
            row_select = 7'(i);
        end
        chk("held_busy", {31'h0, busy}, 32'h1);
        chk("held_p", {16'h0, driver_p}, 32'h0000ED32);
        stop_active();

        // Asynchronous reset mid-DRIVE.
        dead_time = 8'd0;
        start(7'd3, 7'd5, 16'hFF00, 16'h0001);
        s = cyc;
        drv_q.push_back('{cyc: s + 4, p: 16'hF0FE, n: 16'h0F01});
        repeat (6) tick();
        #2;
        drv_q.push_back('{cyc: cyc, p: 16'h0000, n: 16'h0000});
        reset_n = 1'b0;
        #1;
        chk("arst_p", {16'h0, driver_p}, 32'h0);
        chk("arst_n", {16'h0, driver_n}, 32'h0);
        chk("arst_rd", {31'h0, mem_read_n}, 32'h1);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        output_active = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        chk("reads_drained", rd_q.size(), 32'h0);
        chk("drives_drained", drv_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
